// File: rtl/logicap_rle.sv
// logicap_rle: run-length compressor for the logic capture sample stream.
// Consecutive identical samples are merged into one word {count, data}, where
// count holds the run length minus 1. TLAST framing is preserved exactly.
// Optional feature macro: RLE_IDLE_FLUSH_EN. When it is defined, a held run is
// emitted after idle_cycles clocks with no input beat.
//
// state | meaning
// IDLE  | no run held
// RUN   | run held in hold_data/hold_cnt
// FLUSH | last sample of frame held, one TLAST word still to send
module logicap_rle #(
  parameter int size        = 32,
  parameter int cnt_w       = 16,
  parameter int idle_cycles = 1024
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic [size-1:0]       S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  output logic [size+cnt_w-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [cnt_w-1:0] cnt_max = '1;

  state_t                  state, state_nxt;
  logic [size-1:0]         hold_data, hold_data_nxt;
  logic [cnt_w-1:0]        hold_cnt, hold_cnt_nxt;
  logic                    ready_en;
  logic                    out_free, accept, same, sat, idle_hit;
  logic                    emit, emit_last;
  logic [size+cnt_w-1:0]   emit_word;

  assign out_free      = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign S_AXIS_TREADY = ready_en && out_free && (state != FLUSH);
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign same          = (S_AXIS_TDATA == hold_data);
  assign sat           = (hold_cnt == cnt_max);

`ifdef RLE_IDLE_FLUSH_EN
  localparam int idle_w = $clog2(idle_cycles + 1);
  logic [idle_w-1:0] idle_cnt;

  assign idle_hit = (idle_cnt == idle_w'(idle_cycles));

  // Idle timer: counts stalled cycles while a run is held, saturating at the limit
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) idle_cnt <= '0;
    else if (state == RUN && !accept) begin
      if (!idle_hit) idle_cnt <= idle_cnt + 1'b1;
    end else idle_cnt <= '0;
  end
`else
  logic unused_idle;
  assign unused_idle = ^idle_cycles;
  assign idle_hit    = 1'b0;
`endif

  // Input ready is held off until the first clock after reset release
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) ready_en <= 1'b0;
    else                 ready_en <= 1'b1;
  end

  // State register
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state <= IDLE;
    else                 state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && !S_AXIS_TLAST) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          if (same && !sat) begin
            if (S_AXIS_TLAST) state_nxt = IDLE;
          end else if (S_AXIS_TLAST) state_nxt = FLUSH;
        end else if (idle_hit && out_free) state_nxt = IDLE;
      end
      FLUSH: if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath decode: what to emit and how the held run changes
  always_comb begin
    emit          = 1'b0;
    emit_last     = 1'b0;
    emit_word     = {hold_cnt, hold_data};
    hold_data_nxt = hold_data;
    hold_cnt_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          hold_data_nxt = S_AXIS_TDATA;
          hold_cnt_nxt  = '0;
          if (S_AXIS_TLAST) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_word = {{cnt_w{1'b0}}, S_AXIS_TDATA};
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (same && !sat) begin
            if (S_AXIS_TLAST) begin
              emit         = 1'b1;
              emit_last    = 1'b1;
              emit_word    = {hold_cnt + 1'b1, hold_data};
              hold_cnt_nxt = '0;
            end else hold_cnt_nxt = hold_cnt + 1'b1;
          end else begin
            // Differing data or saturated count: close the run, start a new one
            emit          = 1'b1;
            hold_data_nxt = S_AXIS_TDATA;
            hold_cnt_nxt  = '0;
          end
        end else if (idle_hit && out_free) begin
          emit         = 1'b1;
          hold_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        if (out_free) begin
          emit         = 1'b1;
          emit_last    = 1'b1;
          emit_word    = {{cnt_w{1'b0}}, hold_data};
          hold_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // Held run registers
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      hold_data <= '0;
      hold_cnt  <= '0;
    end else begin
      hold_data <= hold_data_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  // Output register: loads only when free, so data stays stable under backpressure
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (emit) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= emit_word;
      M_AXIS_TLAST  <= emit_last;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logicap_rle.sv
// Scoreboard bench for logicap_rle with cnt_w=4 and idle_cycles=8.
module tb_logicap_rle;
  localparam int SIZE = 32;
  localparam int CW   = 4;
  localparam int OW   = SIZE + CW;

  localparam logic [SIZE-1:0] VA = 32'hAAAA_0001;
  localparam logic [SIZE-1:0] VB = 32'hBBBB_0002;
  localparam logic [SIZE-1:0] VC = 32'hCCCC_0003;
  localparam logic [SIZE-1:0] VD = 32'hDDDD_0004;
  localparam logic [SIZE-1:0] VE = 32'hEEEE_0005;
  localparam logic [SIZE-1:0] VF = 32'hFFFF_0006;
  localparam logic [SIZE-1:0] VG = 32'h1234_0007;
  localparam logic [SIZE-1:0] VH = 32'h5678_0008;
  localparam logic [SIZE-1:0] V5 = 32'h0000_0005;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SIZE-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  logic [OW-1:0]   m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int words  = 0;
  logic [OW:0] exp_q[$];

  logicap_rle #(.size(SIZE), .cnt_w(CW), .idle_cycles(8)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TLAST  (s_last),
    .S_AXIS_TREADY (s_ready),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TREADY (m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [CW-1:0] c, input logic [SIZE-1:0] d, input logic l);
    exp_q.push_back({l, c, d});
  endtask

  // Monitor: every completed output handshake is compared against the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        words++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {m_last, m_data});
        end else check("out_word", {m_last, m_data}, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    bit done = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no accept expected accept", name);
    end
  endtask

  task automatic send(input logic [SIZE-1:0] d, input logic l);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    wait_accept("send");
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycles(1);
      n++;
    end
    cycles(2);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    int words0;

    // Reset state
    #12;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);

    // A,A,A,B(last) with one-cycle FLUSH bubble
    expect_word(4'd2, VA, 1'b0);
    expect_word(4'd0, VB, 1'b1);
    send(VA, 0); send(VA, 0); send(VA, 0); send(VB, 1);
    lowcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!s_ready) lowcnt++;
    end
    check("flush_bubble", 64'(lowcnt), 64'd1);
    drain("drain_t1");

    // Saturation: 17 beats of 5, last on the 17th
    expect_word(4'd15, V5, 1'b0);
    expect_word(4'd0, V5, 1'b1);
    for (int i = 0; i < 17; i++) send(V5, (i == 16));
    drain("drain_t2");

    // Alternating A,B,A,B(last)
    expect_word(4'd0, VA, 1'b0);
    expect_word(4'd0, VB, 1'b0);
    expect_word(4'd0, VA, 1'b0);
    expect_word(4'd0, VB, 1'b1);
    send(VA, 0); send(VB, 0); send(VA, 0); send(VB, 1);
    drain("drain_t3");

    // Backpressure: output stalled for 10 cycles with a word pending
    expect_word(4'd1, VE, 1'b0);
    expect_word(4'd1, VF, 1'b0);
    expect_word(4'd0, VG, 1'b1);
    send(VE, 0); send(VE, 0);
    m_ready = 1'b0;
    send(VF, 0);
    s_data = VF; s_last = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_s_ready", 64'(s_ready), 64'd0);
      check("stall_m_word", {27'd0, m_valid, m_data}, {27'd1, 4'd1, VE});
      cycles(1);
    end
    m_ready = 1'b1;
    wait_accept("stall_release");
    s_valid = 1'b0;
    send(VG, 1);
    drain("drain_t4");

    // Reset in the middle of a run
    for (int i = 0; i < 5; i++) send(VH, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_data", 64'(m_data), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    check("midrst_release_ready", 64'(s_ready), 64'd1);
    expect_word(4'd0, VC, 1'b1);
    send(VC, 1);
    drain("drain_t5");

    // Idle timeout behaviour
    words0 = words;
`ifdef RLE_IDLE_FLUSH_EN
    expect_word(4'd2, VD, 1'b0);
`endif
    send(VD, 0); send(VD, 0); send(VD, 0);
    cycles(12);
`ifdef RLE_IDLE_FLUSH_EN
    check("idle_words", 64'(words - words0), 64'd1);
`else
    check("idle_words", 64'(words - words0), 64'd0);
    expect_word(4'd2, VD, 1'b0);
`endif
    expect_word(4'd0, VE, 1'b1);
    send(VE, 1);
    drain("drain_t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
